// File: rtl/code_lock_sequencer.sv
// code_lock_sequencer: multi-digit combination lock with timed unlock, error pulse and lockout
module code_lock_sequencer #(
    parameter int          NUM_DIGITS     = 4,
    parameter logic [31:0] CODE           = 32'h0000_B3D5,
    parameter int          MAX_FAIL       = 3,
    parameter int          OPEN_CYCLES    = 1000,
    parameter int          LOCKOUT_CYCLES = 10000
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int MAXC = OPEN_CYCLES > LOCKOUT_CYCLES ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
    localparam logic [1:0] FAIL_MAX = 2'(MAX_FAIL);

    typedef enum logic [1:0] {ENTRY, OPEN, FAIL, LOCKOUT} state_t;

    logic clk, rst_n;
    logic [3:0] digit;
    logic [1:0] enter_sync, clear_sync;
    logic enter_d, press, clear_s, digit_miss;
    logic [31:0] code_v;
    state_t state, state_n;
    logic [2:0] idx, idx_n;
    logic mismatch, mismatch_n;
    logic [1:0] fail_cnt, fail_n;
    logic [TW-1:0] timer, timer_n;

    assign clk = io_in[0];
    assign rst_n = io_in[1];
    assign digit = io_in[5:2];
    assign code_v = CODE;
    assign press = enter_sync[1] & ~enter_d;
    assign clear_s = clear_sync[1];
    assign digit_miss = digit != code_v[{idx, 2'b00} +: 4];

    // synchronize the strobes and hold all lock state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_sync <= '0;
            clear_sync <= '0;
            enter_d <= 1'b0;
            state <= ENTRY;
            idx <= '0;
            mismatch <= 1'b0;
            fail_cnt <= '0;
            timer <= '0;
        end else begin
            enter_sync <= {enter_sync[0], io_in[6]};
            clear_sync <= {clear_sync[0], io_in[7]};
            enter_d <= enter_sync[1];
            state <= state_n;
            idx <= idx_n;
            mismatch <= mismatch_n;
            fail_cnt <= fail_n;
            timer <= timer_n;
        end
    end

    // next-state: digit entry, open/lockout timing and failure counting
    always_comb begin
        state_n = state;
        idx_n = idx;
        mismatch_n = mismatch;
        fail_n = fail_cnt;
        timer_n = timer;
        case (state)
            ENTRY: begin
                if (clear_s) begin
                    idx_n = '0;
                    mismatch_n = 1'b0;
                end else if (press) begin
                    if (idx < LAST) begin
                        idx_n = idx + 3'd1;
                        mismatch_n = mismatch | digit_miss;
                    end else begin
                        idx_n = '0;
                        mismatch_n = 1'b0;
                        state_n = (!mismatch && !digit_miss) ? OPEN : FAIL;
                        timer_n = (!mismatch && !digit_miss) ? OPEN_LOAD : timer;
                        fail_n = (!mismatch && !digit_miss) ? 2'd0 : fail_cnt;
                    end
                end
            end
            OPEN: begin
                state_n = (clear_s || timer == '0) ? ENTRY : OPEN;
                timer_n = timer == '0 ? timer : timer - TW'(1);
            end
            FAIL: begin
                fail_n = fail_cnt + 2'd1;
                state_n = fail_n == FAIL_MAX ? LOCKOUT : ENTRY;
                timer_n = fail_n == FAIL_MAX ? LOCK_LOAD : timer;
            end
            LOCKOUT: begin
                state_n = timer == '0 ? ENTRY : LOCKOUT;
                fail_n = timer == '0 ? 2'd0 : fail_cnt;
                timer_n = timer == '0 ? timer : timer - TW'(1);
            end
            default: begin
                state_n = ENTRY;
                idx_n = '0;
                mismatch_n = 1'b0;
            end
        endcase
    end

    assign io_out = {fail_cnt, state == ENTRY ? idx : 3'd0,
                     state == LOCKOUT, state == FAIL, state == OPEN};
endmodule

// File: tb/tb_code_lock_sequencer.sv
// tb_code_lock_sequencer: directed checks of entry, failure, lockout, clear and reset behaviour
module tb_code_lock_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, enter = 1'b0, clr = 1'b0;
    logic [3:0] digit = 4'h0;
    logic [7:0] io_in, io_out;
    logic unlock, err, lockout;
    logic [2:0] idx;
    logic [1:0] fails;
    int total = 0, bad = 0;

    assign io_in = {clr, enter, digit, rst_n, clk};
    assign unlock = io_out[0];
    assign err = io_out[1];
    assign lockout = io_out[2];
    assign idx = io_out[5:3];
    assign fails = io_out[7:6];

    code_lock_sequencer #(
        .NUM_DIGITS(4), .CODE(32'h0000_B3D5), .MAX_FAIL(3),
        .OPEN_CYCLES(4), .LOCKOUT_CYCLES(8)
    ) dut (
        .io_in(io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic press_hold(input logic [3:0] d);
        @(negedge clk);
        digit = d;
        enter = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_key();
        @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int k = 0; k < 4; k++) begin
            press_hold(c[4*k +: 4]);
            if (k < 3) release_key();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enter = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (io_out !== 8'h00) begin bad++; $display("FAIL reset_held got=%h exp=00", io_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (io_out !== 8'h00) begin bad++; $display("FAIL reset_first_clk got=%h exp=00", io_out); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_correct();
        press_hold(4'h5);
        total++; if (idx !== 3'd1) begin bad++; $display("FAIL correct_idx1 got=%0d exp=1", idx); end
        release_key();
        press_hold(4'hD);
        total++; if (idx !== 3'd2) begin bad++; $display("FAIL correct_idx2 got=%0d exp=2", idx); end
        release_key();
        press_hold(4'h3);
        total++; if (idx !== 3'd3) begin bad++; $display("FAIL correct_idx3 got=%0d exp=3", idx); end
        release_key();
        @(negedge clk);
        digit = 4'hB;
        enter = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({unlock, idx} !== {1'b0, 3'd3}) begin bad++; $display("FAIL correct_pre_open got=%b/%0d exp=0/3", unlock, idx); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if ({unlock, idx} !== {1'b1, 3'd0}) begin bad++; $display("FAIL correct_open%0d got=%b/%0d exp=1/0", i, unlock, idx); end
            @(posedge clk);
            #1;
        end
        total++; if ({unlock, idx} !== {1'b0, 3'd0}) begin bad++; $display("FAIL correct_close got=%b/%0d exp=0/0", unlock, idx); end
        release_key();
    endtask

    task automatic test_wrong_digit();
        press_hold(4'h5);
        release_key();
        press_hold(4'hD);
        release_key();
        press_hold(4'h7);
        total++; if (idx !== 3'd3) begin bad++; $display("FAIL wrong_idx3 got=%0d exp=3", idx); end
        release_key();
        press_hold(4'hB);
        total++; if ({err, unlock, fails} !== {1'b1, 1'b0, 2'd0}) begin bad++; $display("FAIL wrong_err got=%b/%b/%0d exp=1/0/0", err, unlock, fails); end
        @(posedge clk);
        #1;
        total++; if ({err, unlock, fails} !== {1'b0, 1'b0, 2'd1}) begin bad++; $display("FAIL wrong_after got=%b/%b/%0d exp=0/0/1", err, unlock, fails); end
        release_key();
    endtask

    task automatic test_lockout();
        do_reset();
        for (int n = 0; n < 2; n++) begin
            enter_code(16'h0000);
            total++; if (err !== 1'b1) begin bad++; $display("FAIL lock_err%0d got=%b exp=1", n, err); end
            @(posedge clk);
            #1;
            total++; if (fails !== 2'(n + 1)) begin bad++; $display("FAIL lock_cnt%0d got=%0d exp=%0d", n, fails, n + 1); end
            release_key();
        end
        enter_code(16'h0000);
        total++; if ({err, fails} !== {1'b1, 2'd2}) begin bad++; $display("FAIL lock_err2 got=%b/%0d exp=1/2", err, fails); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            total++; if ({lockout, unlock, fails, idx} !== {1'b1, 1'b0, 2'd3, 3'd0}) begin bad++; $display("FAIL lock_hold%0d got=%b/%b/%0d/%0d exp=1/0/3/0", i, lockout, unlock, fails, idx); end
            enter = (i >= 2 && i <= 4);
            digit = 4'h5;
            clr = (i == 3 || i == 4);
            @(posedge clk);
            #1;
        end
        total++; if ({lockout, fails, idx} !== {1'b0, 2'd0, 3'd0}) begin bad++; $display("FAIL lock_exit got=%b/%0d/%0d exp=0/0/0", lockout, fails, idx); end
        repeat (2) @(negedge clk);
        enter_code(16'hB3D5);
        total++; if (unlock !== 1'b1) begin bad++; $display("FAIL lock_reopen got=%b exp=1", unlock); end
        release_key();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clear();
        press_hold(4'h5);
        release_key();
        press_hold(4'hD);
        total++; if (idx !== 3'd2) begin bad++; $display("FAIL clear_pre got=%0d exp=2", idx); end
        release_key();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (idx !== 3'd2) begin bad++; $display("FAIL clear_latency got=%0d exp=2", idx); end
        @(posedge clk);
        #1;
        total++; if ({idx, fails} !== {3'd0, 2'd0}) begin bad++; $display("FAIL clear_idx got=%0d/%0d exp=0/0", idx, fails); end
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        press_hold(4'h5);
        release_key();
        @(negedge clk);
        clr = 1'b1;
        enter = 1'b1;
        digit = 4'hD;
        repeat (3) @(posedge clk);
        #1;
        total++; if (idx !== 3'd0) begin bad++; $display("FAIL clear_press got=%0d exp=0", idx); end
        @(negedge clk);
        clr = 1'b0;
        enter = 1'b0;
        repeat (3) @(negedge clk);
        enter_code(16'hB3D5);
        total++; if ({unlock, idx} !== {1'b1, 3'd0}) begin bad++; $display("FAIL clear_unlock got=%b/%0d exp=1/0", unlock, idx); end
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (unlock !== 1'b1) begin bad++; $display("FAIL clear_open_hold got=%b exp=1", unlock); end
        @(posedge clk);
        #1;
        total++; if (unlock !== 1'b0) begin bad++; $display("FAIL clear_open_drop got=%b exp=0", unlock); end
        @(negedge clk);
        clr = 1'b0;
        enter = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_held_reset();
        @(negedge clk);
        digit = 4'h5;
        enter = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++; if (idx !== 3'd1) begin bad++; $display("FAIL held_idx got=%0d exp=1", idx); end
        release_key();
        press_hold(4'hD);
        release_key();
        press_hold(4'h3);
        release_key();
        press_hold(4'hB);
        @(posedge clk);
        #1;
        total++; if (unlock !== 1'b1) begin bad++; $display("FAIL held_unlock got=%b exp=1", unlock); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (io_out !== 8'h00) begin bad++; $display("FAIL async_reset got=%h exp=00", io_out); end
        enter = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (io_out !== 8'h00) begin bad++; $display("FAIL reset_release got=%h exp=00", io_out); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_fail();
        enter_code(16'h1234);
        @(posedge clk);
        #1;
        total++; if (fails !== 2'd1) begin bad++; $display("FAIL rfail_cnt got=%0d exp=1", fails); end
        release_key();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (fails !== 2'd0) begin bad++; $display("FAIL rfail_lost got=%0d exp=0", fails); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (io_out !== 8'h00) begin bad++; $display("FAIL rfail_after got=%h exp=00", io_out); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_wrong_digit();
        test_lockout();
        test_clear();
        test_held_reset();
        test_reset_fail();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/code_lock_sequencer.md
Name: code_lock_sequencer

Overview:
- Sequential combination-lock controller for the TinyTapeout 8-bit pin interface.
- Digits arrive one at a time on a 4-bit nibble. Each digit is latched by an enter strobe and compared with a parameterized code sequence.
- Outputs a timed unlock, a 1-cycle error pulse on a wrong code, and a lockout after repeated failures.
- Replaces single-cycle, all-pins-at-once pattern detection with a stateful multi-digit entry sequencer.

Parameters:
- NUM_DIGITS, 4, code length in digits; legal range 1..8.
- CODE, 32'h0000_B3D5, digit k = CODE[4k+3:4k]; digit 0 is entered first; bits above 4*NUM_DIGITS ignored.
- MAX_FAIL, 3, consecutive failed codes that trigger lockout; legal range 1..3.
- OPEN_CYCLES, 1000, clocks the unlock output stays high; must be >= 1.
- LOCKOUT_CYCLES, 10000, clocks spent in lockout; must be >= 1.

Ports:
- io_in[0]  input  1  clock; all flops on its rising edge.
- io_in[1]  input  1  rst_n; asynchronous assert, active-low reset.
- io_in[5:2]  input  4  digit value; sampled on the press cycle, no synchronizer required.
- io_in[6]  input  1  enter strobe; asynchronous, 2-FF synchronized, rising-edge detected.
- io_in[7]  input  1  clear; asynchronous, 2-FF synchronized, level-sensitive.
- io_out[0]  output  1  unlock; high only in state OPEN.
- io_out[1]  output  1  err; 1-cycle pulse on each failed code.
- io_out[2]  output  1  lockout; high only in state LOCKOUT.
- io_out[5:3]  output  3  digit index (number of digits entered so far).
- io_out[7:6]  output  2  consecutive failure count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ENTRY; idx, mismatch, fail_cnt, timer all 0.
  - Both synchronizers and the edge-detect register cleared.
  - All io_out bits 0 while reset is held and on the first clock after release.
- Strobes:
  - press = enter_s & ~enter_d, where enter_s is the 2nd sync stage and enter_d is enter_s delayed one clock.
  - One press per low-to-high transition. A held strobe is never a repeat press.
  - press acts on the 3rd rising clock edge after io_in[6] is first sampled high.
- ENTRY:
  - On press, if the digit != CODE digit[idx], set mismatch.
  - If idx < NUM_DIGITS-1: idx++.
  - Otherwise, if mismatch==0 and the last digit matches: go to OPEN, timer=OPEN_CYCLES-1, fail_cnt=0. Else go to FAIL.
  - idx and mismatch clear on every exit from ENTRY.
- Clear in ENTRY:
  - clear_s high: idx=0, mismatch=0, state stays ENTRY, fail_cnt unchanged.
  - clear_s and press in the same cycle: clear wins, the digit is discarded.
- OPEN:
  - unlock=1; timer decrements each clock; at timer==0 go to ENTRY.
  - clear_s high ends OPEN early: go to ENTRY next clock.
  - press is ignored and does not count as a digit.
- FAIL (exactly one cycle):
  - err=1; fail_cnt++.
  - If the new count == MAX_FAIL: go to LOCKOUT, timer=LOCKOUT_CYCLES-1. Else go to ENTRY.
- LOCKOUT:
  - lockout=1; press and clear ignored; timer decrements.
  - At timer==0: go to ENTRY, fail_cnt=0.
- Output mapping:
  - io_out[5:3] = idx in ENTRY, 0 in other states.
  - io_out[7:6] = fail_cnt; it reads MAX_FAIL during LOCKOUT.
- Register outputs:
  - All outputs are decoded from registered state and counters.
  - No combinational path from io_in to io_out.
- Timer sizing: the timer is wide enough for max(OPEN_CYCLES, LOCKOUT_CYCLES)-1. No wrap: it stops at 0 and the state exits.
- Reset mid-operation: an immediate return to the reset state from any state, including mid-lockout. fail_cnt is lost; this is intended.
- Unused state encodings: recover to ENTRY on the next clock.

Test Plan:
- Parameters for the bench: OPEN_CYCLES=4, LOCKOUT_CYCLES=8, MAX_FAIL=3, CODE=16'hB3D5.
- Correct code: press digits 5,D,3,B, each strobe high 3 clocks and low 3 clocks.
  - io_out[5:3] steps 1,2,3 after each press.
  - unlock rises 3 clocks after the 4th strobe edge, stays high exactly 4 clocks, then idx=0.
- Wrong middle digit: enter 5,D,7,B.
  - No early abort: idx reaches 3.
  - err pulses 1 clock after the 4th press; fail_cnt=1; unlock never rises.
- Lockout: three wrong codes in a row.
  - The 3rd err pulse is followed by lockout=1 for 8 clocks with fail_cnt=3.
  - Presses during lockout have no effect.
  - After lockout, fail_cnt=0 and a correct code unlocks.
- Clear:
  - Enter 5,D, then raise clear: idx returns to 0.
  - Clear and press in the same cycle: the digit is discarded.
  - A subsequent full correct code unlocks.
  - Clear during OPEN: unlock drops 3 clocks after the clear pin rises.
- Held strobe / reset: keep enter high for 20 clocks; exactly one digit is registered.
  - Assert rst_n low mid-OPEN: unlock drops asynchronously.
  - After release, all outputs are 0 and fail_cnt is 0.
